any_gate_sweeper: RTL and testbench

- Self-test stimulus/checker stage that sits directly upstream of the N-input selectable gate (AND/XOR/XNOR/OR).
- Drives the gate's `gate_in` and `gate_select` through every input vector for all four gate types, then samples the returned `gate_out`.
- Compares each sample against an internally computed expected value and reports pass/fail, error count and the first failing vector.
- Used for bring-up and built-in self-test of the gate array.

---
 rtl/any_gate_sweeper.sv | 171 +++++++++++++++++
 tb/tb_any_gate_sweeper.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/any_gate_sweeper.sv
// any_gate_sweeper: built-in self-test driver/checker for the N-input
// selectable gate (AND/XOR/XNOR/OR). Walks every input vector for every gate
// type, samples gate_out after a settle window and tallies mismatches.
// Optional build macro: ANY_GATE_STOP_ON_ERR_EN ends the sweep at the first
// mismatch instead of running the full vector space.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep are held
// DRIVE | current vector on gate_in/gate_select, settle counter running
// CHECK | gate_out sampled and compared against the expected value
// DONE  | one-cycle completion pulse, pass resolved
module any_gate_sweeper #(
  parameter int N      = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = N + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             gate_out,
  output logic [N-1:0]     gate_in,
  output logic [1:0]       gate_select,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_sel,
  output logic [N-1:0]     first_fail_vec
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

`ifdef ANY_GATE_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     vec_q, vec_d;
  logic [1:0]       sel_q, sel_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       ffsel_q, ffsel_d;
  logic [N-1:0]     ffvec_q, ffvec_d;

  logic expected;
  logic mismatch;
  logic last_vec;

  // Expected gate response for the vector currently driven.
  always_comb begin
    expected = 1'b0;
    case (sel_q)
      2'b00:   expected = &vec_q;
      2'b01:   expected = ^vec_q;
      2'b10:   expected = ~^vec_q;
      default: expected = |vec_q;
    endcase
    mismatch = (state_q == S_CHECK) && (gate_out != expected);
    last_vec = (sel_q == 2'b11) && (&vec_q);
  end

  // Sweep sequencing, error tally and first-failure capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    sel_d   = sel_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ffv_d   = ffv_q;
    ffsel_d = ffsel_q;
    ffvec_d = ffvec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          cnt_d   = SETTLE_LOAD;
          vec_d   = '0;
          sel_d   = 2'b00;
          err_d   = '0;
          pass_d  = 1'b0;
          ffv_d   = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CHECK: begin
        // The comparison is recorded even when abort lands on this cycle.
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffsel_d = sel_q;
            ffvec_d = vec_q;
          end
        end
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else if (last_vec || (STOP_ON_ERR && mismatch)) begin
          // Vector outputs hold so the final (or failing) vector stays visible.
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_DRIVE;
          cnt_d   = SETTLE_LOAD;
          vec_d   = vec_q + 1'b1;
          if (&vec_q) sel_d = sel_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      sel_q   <= 2'b00;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
      ffsel_q <= 2'b00;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffsel_q <= ffsel_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign gate_in          = vec_q;
  assign gate_select      = sel_q;
  assign busy             = (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_sel   = ffsel_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_any_gate_sweeper.sv
// tb_any_gate_sweeper: drives any_gate_sweeper with a configurable faulty
// gate and checks every cycle against a timeline-based reference model.
module tb_any_gate_sweeper;
  localparam int N      = 2;
  localparam int SETTLE = 1;
  localparam int ERR_W  = N + 3;
  localparam int NV     = 1 << N;
  localparam int MW     = 4 * NV;
  localparam int TOTAL  = 4 * NV * (SETTLE + 1);

`ifdef ANY_GATE_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             gate_out;
  logic [N-1:0]     gate_in;
  logic [1:0]       gate_select;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [1:0]       first_fail_sel;
  logic [N-1:0]     first_fail_vec;

  int checks = 0;
  int failures = 0;

  // gate fault model: 0 = correct xor per-vector flip mask, 1 = XOR/XNOR swapped, 2 = stuck at 0
  int            gmode = 0;
  logic [MW-1:0] fmask = '0;

  any_gate_sweeper #(.N(N), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(gate_out),
    .gate_in(gate_in), .gate_select(gate_select), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail_valid(first_fail_valid),
    .first_fail_sel(first_fail_sel), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  function automatic logic ref_gate(input int sel, input int vec);
    int ones;
    ones = $countones(vec);
    case (sel)
      0:       return logic'(vec == NV - 1);
      1:       return logic'(ones % 2 == 1);
      2:       return logic'(ones % 2 == 0);
      default: return logic'(vec != 0);
    endcase
  endfunction

  function automatic logic dut_gate(input int mode, input logic [MW-1:0] mask,
                                    input int sel, input int vec);
    case (mode)
      1:       return (sel == 1) ? ref_gate(2, vec) : (sel == 2) ? ref_gate(1, vec) : ref_gate(sel, vec);
      2:       return 1'b0;
      default: return ref_gate(sel, vec) ^ mask[sel * NV + vec];
    endcase
  endfunction

  assign gate_out = dut_gate(gmode, fmask, int'(gate_select), int'(gate_in));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is a timeline of TOTAL cycles; cycle k (1-based)
  // drives vector (k-1)/(SETTLE+1) and checks it on the last cycle of its slot.
  bit m_active, m_done, m_pass, m_ffv;
  int m_k, m_err, m_sel, m_vec, m_ffsel, m_ffvec;
  int m_v;
  bit m_chk, m_mis, m_stop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_pass = 0; m_ffv = 0;
      m_k = 0; m_err = 0; m_sel = 0; m_vec = 0; m_ffsel = 0; m_ffvec = 0;
    end else if (m_active) begin
      m_v   = (m_k - 1) / (SETTLE + 1);
      m_chk = ((m_k - 1) % (SETTLE + 1)) == SETTLE;
      m_mis = m_chk && (dut_gate(gmode, fmask, m_v / NV, m_v % NV) != ref_gate(m_v / NV, m_v % NV));
      if (m_mis) begin
        if (m_err < (1 << ERR_W) - 1) m_err++;
        if (!m_ffv) begin
          m_ffv = 1; m_ffsel = m_v / NV; m_ffvec = m_v % NV;
        end
      end
      m_stop = m_chk && ((m_v == 4 * NV - 1) || (STOP && m_mis));
      if (abort) begin
        m_active = 0; m_pass = 0;
      end else if (m_stop) begin
        m_active = 0; m_done = 1; m_pass = (m_err == 0);
      end else begin
        m_k++;
        m_v   = (m_k - 1) / (SETTLE + 1);
        m_sel = m_v / NV;
        m_vec = m_v % NV;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start) begin
      m_active = 1; m_k = 1; m_err = 0; m_pass = 0; m_ffv = 0; m_sel = 0; m_vec = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("pass", int'(pass), int'(m_pass));
      check("err_count", int'(err_count), m_err);
      check("first_fail_valid", int'(first_fail_valid), int'(m_ffv));
      if (m_ffv) begin
        check("first_fail_sel", int'(first_fail_sel), m_ffsel);
        check("first_fail_vec", int'(first_fail_vec), m_ffvec);
      end
      check("gate_select", int'(gate_select), m_sel);
      check("gate_in", int'(gate_in), m_vec);
    end
  end

  // Pulse start (optionally with abort), then watch until done or the abort settles.
  // n = cycles from the start-sampling cycle to the done pulse, 0 if none.
  task automatic sweep(input bit with_abort, input int noise_pct, input int abort_at, output int n);
    @(posedge clk); #1 start = 1'b1; abort = with_abort;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      abort = 1'b0;
      if (done) begin
        n = i;
        break;
      end
      if (abort_at > 0 && i >= abort_at + 3) break;
      if (abort_at > 0 && i == abort_at) abort = 1'b1;
      start = (noise_pct > 0 && (abort_at == 0 || i < abort_at) &&
               $urandom_range(99) < noise_pct) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_gate_in", int'(gate_in), 0);

    // correct gate: full sweep passes
    gmode = 0; fmask = '0;
    sweep(1'b0, 0, 0, n);
    check("t1_latency", n, 33);
    check("t1_pass", int'(pass), 1);
    check("t1_err", int'(err_count), 0);
    check("t1_ffv", int'(first_fail_valid), 0);
    check("t1_last_sel", int'(gate_select), 3);
    check("t1_last_vec", int'(gate_in), 3);
    repeat (2) @(negedge clk);

    // XOR/XNOR swapped
    gmode = 1;
    sweep(1'b0, 0, 0, n);
    check("t2_latency", n, STOP ? 11 : 33);
    check("t2_err", int'(err_count), STOP ? 1 : 8);
    check("t2_ff_sel", int'(first_fail_sel), 1);
    check("t2_ff_vec", int'(first_fail_vec), 0);
    check("t2_pass", int'(pass), 0);
    repeat (2) @(negedge clk);

    // stuck-at-0
    gmode = 2;
    sweep(1'b0, 0, 0, n);
    check("t3_latency", n, STOP ? 9 : 33);
    check("t3_err", int'(err_count), STOP ? 1 : 8);
    check("t3_ff_sel", int'(first_fail_sel), 0);
    check("t3_ff_vec", int'(first_fail_vec), 3);
    check("t3_pass", int'(pass), 0);
    if (STOP) begin
      check("t3_stop_sel", int'(gate_select), 0);
      check("t3_stop_vec", int'(gate_in), 3);
    end
    repeat (2) @(negedge clk);

    // abort at cycle 10, then a clean sweep
    gmode = 0; fmask = '0;
    sweep(1'b0, 0, 10, n);
    check("t4_no_done", n, 0);
    check("t4_busy", int'(busy), 0);
    check("t4_pass", int'(pass), 0);
    sweep(1'b0, 0, 0, n);
    check("t4_rerun_latency", n, 33);
    check("t4_rerun_pass", int'(pass), 1);

    // asynchronous reset at cycle 12 of a stuck-at sweep
    gmode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_pass", int'(pass), 0);
    check("t5_err", int'(err_count), 0);
    check("t5_ffv", int'(first_fail_valid), 0);
    check("t5_ff_sel", int'(first_fail_sel), 0);
    check("t5_ff_vec", int'(first_fail_vec), 0);
    check("t5_gate_in", int'(gate_in), 0);
    check("t5_gate_select", int'(gate_select), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // start pulses during a sweep are ignored
    gmode = 0;
    sweep(1'b0, 30, 0, n);
    check("t6_latency", n, 33);
    check("t6_pass", int'(pass), 1);

    // start and abort together in IDLE: start wins
    sweep(1'b1, 0, 0, n);
    check("t7_latency", n, 33);
    check("t7_pass", int'(pass), 1);

    // randomized faults, start noise and aborts
    for (int it = 0; it < 16; it++) begin
      gmode = $urandom_range(2);
      fmask = ($urandom_range(3) == 0) ? '0 : MW'($urandom);
      sweep(1'b0, 20, ($urandom_range(3) == 0) ? $urandom_range(TOTAL, 1) : 0, n);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
